// File: rtl/arf_multiport.sv
`default_nettype none
// ============================================================================
// Module   : arf_multiport
// Brief    : Architectural register file with retire write ports, registered
//            read ports with optional write bypass, and a debug dump engine.
// Revision : 1.0
// ============================================================================
module arf_multiport #(
    parameter int DATA_W   = 32,
    parameter int AR_SIZE  = 6,
    parameter int AR_ARRAY = 64,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*AR_SIZE-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_valid,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*AR_SIZE-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic                        dump_start,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic [AR_SIZE-1:0]          dump_addr,
    output logic [DATA_W-1:0]           dump_data,
    output logic                        dump_busy,
    output logic                        dump_done
);

    localparam logic [1:0]         c_ST_IDLE = 2'd0;
    localparam logic [1:0]         c_ST_DUMP = 2'd1;
    localparam logic [1:0]         c_ST_DONE = 2'd2;
    localparam logic [AR_SIZE:0]   c_LIMIT   = (AR_SIZE+1)'(AR_ARRAY);
    localparam logic [AR_SIZE-1:0] c_LAST    = AR_SIZE'(AR_ARRAY - 1);

    logic [DATA_W-1:0] r_mem [AR_ARRAY];

    // Address 0 is hardwired to zero, so it is never a legal write target.
    function automatic logic f_writable(input logic [AR_SIZE-1:0] a);
        return (a != '0) && ({1'b0, a} < c_LIMIT);
    endfunction

    // Value seen by a read issued this cycle; later write ports override earlier ones.
    function automatic logic [DATA_W-1:0] f_lookup(input logic [AR_SIZE-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (f_writable(a)) begin
            v = r_mem[a];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AR_SIZE +: AR_SIZE] == a))
                        v = wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
        return v;
    endfunction

    // Last non-blocking assignment wins, giving the highest port priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < AR_ARRAY; k++)
                r_mem[k] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && f_writable(wr_addr[j*AR_SIZE +: AR_SIZE]))
                    r_mem[wr_addr[j*AR_SIZE +: AR_SIZE]] <= wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AR_SIZE-1:0] w_addr;
        logic [DATA_W-1:0]  r_data;
        logic               r_valid;

        assign w_addr = rd_addr[i*AR_SIZE +: AR_SIZE];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= rd_en[i];
                if (rd_en[i])
                    r_data <= f_lookup(w_addr);
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = r_data;
        assign rd_valid[i]                 = r_valid;
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [AR_SIZE-1:0] r_idx;
    logic [DATA_W-1:0]  r_dump_data;
    logic               w_start;
    logic               w_hs;
    logic               w_last;

    assign w_start = (r_state == c_ST_IDLE) && dump_start;
    assign w_hs    = (r_state == c_ST_DUMP) && dump_ready;
    assign w_last  = (r_idx == c_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_dump_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_idx       <= '0;
                r_dump_data <= '0;   // entry 0 always reads as zero
            end else if (w_hs && !w_last) begin
                r_idx       <= r_idx + 1'b1;
                r_dump_data <= f_lookup(r_idx + 1'b1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (dump_start) w_state_nxt = c_ST_DUMP;
            c_ST_DUMP: if (dump_ready && w_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (r_state)
            c_ST_DUMP: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
            end
            c_ST_DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign dump_addr = r_idx;
    assign dump_data = r_dump_data;

endmodule
`default_nettype wire

// File: tb/tb_arf_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_arf_multiport
// Brief    : Self-checking bench for arf_multiport: three configurations
//            (bypass, no bypass, 40-entry) driven in lockstep against a model.
// Revision : 1.0
// ============================================================================
module tb_arf_multiport;

    localparam int DW = 32;
    localparam int AS = 6;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int SMALL = 40;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     rd_en;
    logic [NR*AS-1:0]  rd_addr;
    logic [NW-1:0]     wr_en;
    logic [NW*AS-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              dump_start;
    logic              dump_ready;

    logic [NR*DW-1:0]  rd_data_a, rd_data_b, rd_data_c;
    logic [NR-1:0]     rd_valid_a, rd_valid_b, rd_valid_c;
    logic              dump_valid_a, dump_valid_b, dump_valid_c;
    logic [AS-1:0]     dump_addr_a, dump_addr_b, dump_addr_c;
    logic [DW-1:0]     dump_data_a, dump_data_b, dump_data_c;
    logic              dump_busy_a, dump_busy_b, dump_busy_c;
    logic              dump_done_a, dump_done_b, dump_done_c;

    logic [DW-1:0] m_full  [64];
    logic [DW-1:0] m_small [SMALL];
    logic [DW-1:0] exp_a [NR];
    logic [DW-1:0] exp_b [NR];
    logic [DW-1:0] exp_c [NR];
    logic [NR-1:0] exp_vld;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arf_multiport #(.BYPASS(1)) dut_a (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .dump_start(dump_start),
        .dump_valid(dump_valid_a), .dump_ready(dump_ready),
        .dump_addr(dump_addr_a), .dump_data(dump_data_a),
        .dump_busy(dump_busy_a), .dump_done(dump_done_a));

    arf_multiport #(.BYPASS(0)) dut_b (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .dump_start(dump_start),
        .dump_valid(dump_valid_b), .dump_ready(dump_ready),
        .dump_addr(dump_addr_b), .dump_data(dump_data_b),
        .dump_busy(dump_busy_b), .dump_done(dump_done_b));

    arf_multiport #(.AR_ARRAY(SMALL)) dut_c (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .dump_start(dump_start),
        .dump_valid(dump_valid_c), .dump_ready(dump_ready),
        .dump_addr(dump_addr_c), .dump_data(dump_data_c),
        .dump_busy(dump_busy_c), .dump_done(dump_done_c));

    // One clock: predict read results from the model, then commit writes to it.
    task automatic step();
        int ra, wa;
        logic [DW-1:0] oldf, newf, olds, news;
        for (int i = 0; i < NR; i++) begin
            if (!rstn) begin
                exp_a[i] = '0; exp_b[i] = '0; exp_c[i] = '0;
            end else if (rd_en[i]) begin
                ra   = int'(rd_addr[i*AS +: AS]);
                oldf = (ra != 0) ? m_full[ra] : '0;
                olds = (ra != 0 && ra < SMALL) ? m_small[ra] : '0;
                newf = oldf;
                news = olds;
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && int'(wr_addr[j*AS +: AS]) == ra && ra != 0) begin
                        newf = wr_data[j*DW +: DW];
                        if (ra < SMALL) news = wr_data[j*DW +: DW];
                    end
                end
                exp_a[i] = newf; exp_b[i] = oldf; exp_c[i] = news;
            end
        end
        exp_vld = rstn ? rd_en : '0;
        @(posedge clk);
        if (!rstn) begin
            for (int k = 0; k < 64; k++) m_full[k] = '0;
            for (int k = 0; k < SMALL; k++) m_small[k] = '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                wa = int'(wr_addr[j*AS +: AS]);
                if (wr_en[j] && wa != 0) begin
                    m_full[wa] = wr_data[j*DW +: DW];
                    if (wa < SMALL) m_small[wa] = wr_data[j*DW +: DW];
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        step();
        step();
        checks += 3;
        if ({rd_valid_a, rd_valid_b, rd_valid_c} !== '0) begin
            errors++; $display("FAIL reset rd_valid: got %b %b %b exp 0", rd_valid_a, rd_valid_b, rd_valid_c);
        end
        if ({rd_data_a, rd_data_b, rd_data_c} !== '0) begin
            errors++; $display("FAIL reset rd_data: got %h %h %h exp 0", rd_data_a, rd_data_b, rd_data_c);
        end
        if ({dump_valid_a, dump_valid_b, dump_valid_c, dump_busy_a, dump_busy_b, dump_busy_c,
             dump_done_a, dump_done_b, dump_done_c, dump_addr_a, dump_addr_b, dump_addr_c,
             dump_data_a, dump_data_b, dump_data_c} !== '0) begin
            errors++; $display("FAIL reset dump outputs: got v=%b%b%b b=%b%b%b d=%b%b%b exp all 0",
                dump_valid_a, dump_valid_b, dump_valid_c, dump_busy_a, dump_busy_b, dump_busy_c,
                dump_done_a, dump_done_b, dump_done_c);
        end
        rstn = 1'b1;
        rd_en = 2'b11;
        rd_addr = {6'd63, 6'd5};
        step();
        rd_en = '0;
        checks += 1;
        if ({rd_valid_a, rd_valid_b, rd_valid_c} !== {3{2'b11}}) begin
            errors++; $display("FAIL reset_read rd_valid: got %b %b %b exp 11", rd_valid_a, rd_valid_b, rd_valid_c);
        end
        for (int i = 0; i < NR; i++) begin
            checks += 3;
            if (rd_data_a[i*DW +: DW] !== exp_a[i]) begin errors++; $display("FAIL reset_read a[%0d]: got %h exp %h", i, rd_data_a[i*DW +: DW], exp_a[i]); end
            if (rd_data_b[i*DW +: DW] !== exp_b[i]) begin errors++; $display("FAIL reset_read b[%0d]: got %h exp %h", i, rd_data_b[i*DW +: DW], exp_b[i]); end
            if (rd_data_c[i*DW +: DW] !== exp_c[i]) begin errors++; $display("FAIL reset_read c[%0d]: got %h exp %h", i, rd_data_c[i*DW +: DW], exp_c[i]); end
        end
    endtask

    task automatic test_write_read();
        wr_en = 2'b11;
        wr_addr = {6'd0, 6'd3};
        wr_data = {32'h0000_1234, 32'hDEAD_BEEF};
        step();
        wr_en = '0;
        rd_en = 2'b11;
        rd_addr = {6'd0, 6'd3};
        step();
        rd_en = '0;
        checks += 2;
        if (rd_data_a[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_read addr3: got %h exp deadbeef", rd_data_a[31:0]); end
        if (rd_data_a[63:32] !== 32'h0) begin errors++; $display("FAIL write_read x0: got %h exp 0", rd_data_a[63:32]); end
        for (int i = 0; i < NR; i++) begin
            checks += 2;
            if (rd_data_b[i*DW +: DW] !== exp_b[i]) begin errors++; $display("FAIL write_read b[%0d]: got %h exp %h", i, rd_data_b[i*DW +: DW], exp_b[i]); end
            if (rd_data_c[i*DW +: DW] !== exp_c[i]) begin errors++; $display("FAIL write_read c[%0d]: got %h exp %h", i, rd_data_c[i*DW +: DW], exp_c[i]); end
        end
    endtask

    task automatic test_conflict_bypass();
        wr_en = 2'b11;
        wr_addr = {6'd7, 6'd7};
        wr_data = {32'h0000_BBBB, 32'h0000_AAAA};
        rd_en = 2'b01;
        rd_addr = {6'd0, 6'd7};
        step();
        wr_en = '0;
        checks += 4;
        if (rd_data_a[31:0] !== 32'h0000_BBBB) begin errors++; $display("FAIL conflict bypass1: got %h exp bbbb", rd_data_a[31:0]); end
        if (rd_data_b[31:0] !== 32'h0) begin errors++; $display("FAIL conflict bypass0: got %h exp 0", rd_data_b[31:0]); end
        if (rd_data_c[31:0] !== exp_c[0]) begin errors++; $display("FAIL conflict small: got %h exp %h", rd_data_c[31:0], exp_c[0]); end
        if ({rd_valid_a, rd_valid_b} !== 4'b0101) begin errors++; $display("FAIL conflict rd_valid: got %b %b exp 01", rd_valid_a, rd_valid_b); end
        step();
        checks += 2;
        if (rd_data_a[31:0] !== 32'h0000_BBBB) begin errors++; $display("FAIL conflict reread a: got %h exp bbbb", rd_data_a[31:0]); end
        if (rd_data_b[31:0] !== 32'h0000_BBBB) begin errors++; $display("FAIL conflict reread b: got %h exp bbbb", rd_data_b[31:0]); end
        rd_en = '0;
        rd_addr = {6'd3, 6'd3};
        step();
        checks += 2;
        if ({rd_valid_a, rd_valid_b} !== 4'b0000) begin errors++; $display("FAIL hold rd_valid: got %b %b exp 00", rd_valid_a, rd_valid_b); end
        if (rd_data_b[31:0] !== 32'h0000_BBBB) begin errors++; $display("FAIL hold rd_data: got %h exp bbbb", rd_data_b[31:0]); end
    endtask

    task automatic test_out_of_range();
        wr_en = 2'b10;
        wr_addr = {6'd45, 6'd0};
        wr_data = {32'h00C0_FFEE, 32'h0};
        step();
        wr_en = '0;
        for (int k = 0; k < 64; k += 2) begin
            rd_en = 2'b11;
            rd_addr = {AS'(k + 1), AS'(k)};
            step();
            for (int i = 0; i < NR; i++) begin
                checks += 3;
                if (rd_data_a[i*DW +: DW] !== exp_a[i]) begin errors++; $display("FAIL oor a addr %0d: got %h exp %h", k + i, rd_data_a[i*DW +: DW], exp_a[i]); end
                if (rd_data_b[i*DW +: DW] !== exp_b[i]) begin errors++; $display("FAIL oor b addr %0d: got %h exp %h", k + i, rd_data_b[i*DW +: DW], exp_b[i]); end
                if (rd_data_c[i*DW +: DW] !== exp_c[i]) begin errors++; $display("FAIL oor c addr %0d: got %h exp %h", k + i, rd_data_c[i*DW +: DW], exp_c[i]); end
            end
            if (k == 44) begin
                checks += 2;
                if (rd_data_c[63:32] !== 32'h0) begin errors++; $display("FAIL oor small addr45: got %h exp 0", rd_data_c[63:32]); end
                if (rd_data_a[63:32] !== 32'h00C0_FFEE) begin errors++; $display("FAIL oor full addr45: got %h exp c0ffee", rd_data_a[63:32]); end
            end
        end
        rd_en = '0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            wr_en = NW'($urandom);
            rd_en = NR'($urandom);
            for (int j = 0; j < NW; j++) begin
                wr_addr[j*AS +: AS] = ($urandom_range(0, 3) == 0) ? AS'($urandom_range(0, 63)) : AS'($urandom_range(0, 9));
                wr_data[j*DW +: DW] = $urandom;
            end
            for (int i = 0; i < NR; i++)
                rd_addr[i*AS +: AS] = ($urandom_range(0, 3) == 0) ? AS'($urandom_range(0, 63)) : AS'($urandom_range(0, 9));
            step();
            checks += 1;
            if ({rd_valid_a, rd_valid_b, rd_valid_c} !== {3{exp_vld}}) begin
                errors++; $display("FAIL random rd_valid cyc %0d: got %b %b %b exp %b", n, rd_valid_a, rd_valid_b, rd_valid_c, exp_vld);
            end
            for (int i = 0; i < NR; i++) begin
                checks += 3;
                if (rd_data_a[i*DW +: DW] !== exp_a[i]) begin errors++; $display("FAIL random a[%0d] cyc %0d: got %h exp %h", i, n, rd_data_a[i*DW +: DW], exp_a[i]); end
                if (rd_data_b[i*DW +: DW] !== exp_b[i]) begin errors++; $display("FAIL random b[%0d] cyc %0d: got %h exp %h", i, n, rd_data_b[i*DW +: DW], exp_b[i]); end
                if (rd_data_c[i*DW +: DW] !== exp_c[i]) begin errors++; $display("FAIL random c[%0d] cyc %0d: got %h exp %h", i, n, rd_data_c[i*DW +: DW], exp_c[i]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_dump_stall();
        int idx = 0;
        int phase = 0;
        int cyc = 0;
        bit finished = 1'b0;
        for (int k = 0; k < 64; k += 2) begin
            wr_en = 2'b11;
            wr_addr = {AS'(k + 1), AS'(k)};
            wr_data = {DW'((k + 1) * 3), DW'(k * 3)};
            step();
        end
        wr_en = '0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        while (!finished && cyc < 400) begin
            dump_ready = (phase % 3 == 0);
            if (idx < 64) begin
                checks += 4;
                if ({dump_valid_a, dump_valid_b, dump_busy_a, dump_done_a} !== 4'b1110) begin
                    errors++; $display("FAIL stall ctrl beat %0d: got v=%b%b busy=%b done=%b exp v=11 busy=1 done=0", idx, dump_valid_a, dump_valid_b, dump_busy_a, dump_done_a);
                end
                if (dump_addr_a !== AS'(idx) || dump_addr_b !== AS'(idx)) begin
                    errors++; $display("FAIL stall addr: got %0d/%0d exp %0d", dump_addr_a, dump_addr_b, idx);
                end
                if (dump_data_a !== DW'(idx * 3)) begin errors++; $display("FAIL stall data a beat %0d: got %h exp %h", idx, dump_data_a, DW'(idx * 3)); end
                if (dump_data_b !== DW'(idx * 3)) begin errors++; $display("FAIL stall data b beat %0d: got %h exp %h", idx, dump_data_b, DW'(idx * 3)); end
                if (dump_ready) idx++;
            end else begin
                checks += 1;
                if ({dump_valid_a, dump_done_a, dump_done_b, dump_busy_a} !== 4'b0111) begin
                    errors++; $display("FAIL stall done: got v=%b done=%b%b busy=%b exp v=0 done=11 busy=1", dump_valid_a, dump_done_a, dump_done_b, dump_busy_a);
                end
                finished = 1'b1;
            end
            phase++;
            step();
            cyc++;
        end
        checks += 2;
        if (!finished) begin errors++; $display("FAIL stall timeout: got beat %0d exp done within 400 cycles", idx); end
        if ({dump_done_a, dump_busy_a} !== 2'b00) begin errors++; $display("FAIL stall after done: got done=%b busy=%b exp 0 0", dump_done_a, dump_busy_a); end
        dump_ready = 1'b0;
    endtask

    task automatic test_dump_writes();
        int idx = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [DW-1:0] ea, eb;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        while (idx < 64 && cyc < 200) begin
            wr_en = '0;
            dump_ready = 1'b1;
            if (idx == 20) begin wr_en = 2'b01; wr_addr = {6'd0, 6'd50}; wr_data = {32'h0, 32'h55}; end
            if (idx == 30 && !held) begin
                dump_ready = 1'b0; held = 1'b1;
                wr_en = 2'b01; wr_addr = {6'd0, 6'd30}; wr_data = {32'h0, 32'h77};
            end
            if (idx == 40) begin wr_en = 2'b10; wr_addr = {6'd41, 6'd0}; wr_data = {32'h4141, 32'h0}; end
            // Beat 41 is loaded on the same edge as its write, exposing the bypass rule.
            ea = (idx == 50) ? 32'h55 : (idx == 41) ? 32'h4141 : DW'(idx * 3);
            eb = (idx == 50) ? 32'h55 : DW'(idx * 3);
            checks += 3;
            if ({dump_valid_a, dump_valid_b} !== 2'b11 || dump_addr_a !== AS'(idx) || dump_addr_b !== AS'(idx)) begin
                errors++; $display("FAIL dumpwr beat %0d: got v=%b%b addr=%0d/%0d exp v=11 addr=%0d", idx, dump_valid_a, dump_valid_b, dump_addr_a, dump_addr_b, idx);
            end
            if (dump_data_a !== ea) begin errors++; $display("FAIL dumpwr data a beat %0d: got %h exp %h", idx, dump_data_a, ea); end
            if (dump_data_b !== eb) begin errors++; $display("FAIL dumpwr data b beat %0d: got %h exp %h", idx, dump_data_b, eb); end
            if (dump_ready) idx++;
            step();
            cyc++;
        end
        wr_en = '0;
        // 64 beats plus one stall cycle, then DONE.
        checks += 2;
        if ({dump_done_a, dump_done_b} !== 2'b11) begin errors++; $display("FAIL dumpwr done: got %b%b exp 11", dump_done_a, dump_done_b); end
        if (cyc != 65) begin errors++; $display("FAIL dumpwr latency: got %0d cycles exp 65", cyc); end
        step();
    endtask

    task automatic test_dump_reset();
        int cyc = 0;
        dump_start = 1'b1;
        dump_ready = 1'b1;
        step();
        dump_start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        checks += 1;
        if (dump_addr_a !== 6'd10 || dump_valid_a !== 1'b1) begin errors++; $display("FAIL dumprst pre: got addr=%0d v=%b exp 10 1", dump_addr_a, dump_valid_a); end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checks += 1;
        if ({dump_valid_a, dump_valid_b, dump_valid_c, dump_busy_a, dump_busy_b, dump_busy_c,
             dump_done_a, dump_done_b, dump_done_c, dump_addr_a, dump_addr_b, dump_addr_c,
             dump_data_a, dump_data_b, dump_data_c} !== '0) begin
            errors++; $display("FAIL dumprst abort: got v=%b%b%b busy=%b%b%b done=%b%b%b exp all 0",
                dump_valid_a, dump_valid_b, dump_valid_c, dump_busy_a, dump_busy_b, dump_busy_c,
                dump_done_a, dump_done_b, dump_done_c);
        end
        while (cyc < 70) begin
            checks += 1;
            if ({dump_done_a, dump_done_b, dump_done_c, dump_busy_a, dump_busy_b, dump_busy_c} !== '0) begin
                errors++; $display("FAIL dumprst idle cyc %0d: got done=%b%b%b busy=%b%b%b exp 0", cyc,
                    dump_done_a, dump_done_b, dump_done_c, dump_busy_a, dump_busy_b, dump_busy_c);
            end
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        for (int k = 0; k < 64; k += 2) begin
            rd_en = 2'b11;
            rd_addr = {AS'(k + 1), AS'(k)};
            step();
            checks += 1;
            if ({rd_data_a, rd_data_b, rd_data_c} !== '0) begin
                errors++; $display("FAIL dumprst entries %0d/%0d: got %h %h %h exp 0", k, k + 1, rd_data_a, rd_data_b, rd_data_c);
            end
        end
        rd_en = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish exp finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_conflict_bypass();
        test_out_of_range();
        test_random();
        test_dump_stall();
        test_dump_writes();
        test_dump_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arf_multiport.md
Name: arf_multiport

Overview:
- Parametrised, clocked Architectural Register File (ARF) for the RISC-V out-of-order core. It holds committed architectural state.
- Provides NUM_WR retire write ports and NUM_RD registered read ports, with optional write-to-read bypass.
- Includes a debug dump engine that streams every register out over a valid/ready channel, for state dumps at test end or on exception.
- Sits between the ROB retire stage and the issue/recovery logic.

Parameters:
- DATA_W, 32, register data width.
- AR_SIZE, 6, architectural address width.
- AR_ARRAY, 64, number of registers; must be ≤ 2^AR_SIZE.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write (retire) ports.
- BYPASS, 1, selects read behaviour on a same-cycle write to the read address: 1 returns the new data, 0 returns the old data.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*AR_SIZE  read addresses; port i occupies bits [i*AR_SIZE +: AR_SIZE].
- rd_data  out  NUM_RD*DATA_W  registered read data.
- rd_valid  out  NUM_RD  high one cycle after an accepted rd_en.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AR_SIZE  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- dump_start  in  1  single-cycle pulse that starts a full-file dump.
- dump_valid  out  1  dump beat present.
- dump_ready  in  1  consumer accepts the current beat.
- dump_addr  out  AR_SIZE  index of the current beat.
- dump_data  out  DATA_W  data of the current beat.
- dump_busy  out  1  high while the dump FSM is not IDLE.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rstn=0 at posedge):
  - All entries cleared to 0.
  - rd_data=0, rd_valid=0.
  - FSM goes to IDLE; dump_valid=0, dump_addr=0, dump_data=0, dump_busy=0, dump_done=0.
  - Reset mid-dump aborts the dump with no dump_done pulse.
- Writes (take effect at posedge):
  - Port j writes entry wr_addr[j] when wr_en[j]=1, wr_addr[j]≠0 and wr_addr[j]<AR_ARRAY.
  - Address 0 is hardwired to 0; writes to it are dropped.
  - Out-of-range addresses are ignored.
  - If several ports write the same address in one cycle, the highest port index wins.
- Reads (1-cycle latency):
  - When rd_en[i]=1 at posedge N, rd_data[i] carries the entry value and rd_valid[i]=1 during cycle N+1.
  - When rd_en[i]=0, rd_valid[i]=0 and rd_data[i] holds its previous value.
  - Address 0 and out-of-range addresses return 0.
  - Same-cycle write to the read address: BYPASS=1 returns the winning write data; BYPASS=0 returns the pre-write value.
  - All read ports are independent; any combination of identical addresses is legal.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE: dump_start=1 → DUMP. The index is set to 0 and beat 0 is loaded (dump_addr=0, dump_data=entry 0), so dump_valid=1 on the next cycle. dump_start is ignored in any state other than IDLE.
  - DUMP: dump_valid=1. dump_addr and dump_data stay stable while dump_ready=0.
  - On a handshake (dump_valid and dump_ready) with index<AR_ARRAY-1: index+1, and the next beat is loaded from the array. The loaded value follows the BYPASS rule for writes in that same cycle.
  - On a handshake with index=AR_ARRAY-1: go to DONE and drop dump_valid.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
  - dump_busy=1 in DUMP and DONE.
  - Retire writes continue during a dump. A beat reflects the entry value at the cycle it was loaded; later writes to an already-loaded index do not alter the held beat.
  - Back-to-back: with dump_ready held high, one beat per cycle. Total dump time is AR_ARRAY+2 cycles from dump_start to dump_done.

Test Plan:
- Reset then read: rstn=0 for 2 cycles; read addrs 5 and 63 → rd_data=0/0 with rd_valid=11 one cycle later.
- Write/read and x0: write port0 addr3=0xDEADBEEF, port1 addr0=0x1234; next cycle read addr3 and addr0 → 0xDEADBEEF and 0.
- Write conflict and bypass: same cycle, wr0 addr7=0xAAAA, wr1 addr7=0xBBBB, rd0 addr7. BYPASS=1 → 0xBBBB one cycle later; BYPASS=0 → old value 0. Read again the next cycle → 0xBBBB for both settings.
- Out-of-range: AR_ARRAY=40; write addr 45, then read addr 45 → 0, and no entry is modified.
- Dump with stalls: preload entry k=k*3; dump_start with dump_ready toggling 1,0,0,1… → addrs 0..63 in order, data k*3, beats stable during stalls, and dump_done a single pulse after beat 63.
- Dump with concurrent writes and reset: mid-dump, write addr 50=0x55 before beat 50 loads → beat 50 = 0x55. Then start a second dump and assert rstn=0 at beat 10 → dump_valid=0, dump_busy=0, no dump_done, all entries read 0.
